video_box_overlay: RTL and testbench
====================================

# video_box_overlay

Parametrised multi-box OSD overlay on the video input path, sitting between the input sync/data delay taps and the output registers. It generalises the single fixed rectangle to N_BOX independently configurable boxes, each with outline or filled mode, colour, and replace or 50 % blend mixing. Box configuration is double-buffered and committed at frame start. Sync, de and data pass through with a fixed 4-cycle latency.

## Interface
- N_BOX, 4, number of boxes (1..16); box 0 has highest priority
- W_PIX, 24, pixel width; multiple of 8 (8-bit lanes)
- W_COORD, 12, coordinate/size width
- W_THK, 4, border thickness width
- clk  in  1  pixel clock; all logic on posedge
- rstn  in  1  asynchronous active-low reset
- vsync, hsync, de  in  1  input video timing
- data  in  W_PIX  input pixel
- cfg_we  in  1  write strobe for the pending config of box cfg_idx
- cfg_idx  in  max(1,$clog2(N_BOX))  box index; idx >= N_BOX ignored
- cfg_en  in  1  box enable
- cfg_blend  in  1  0 = replace, 1 = 50 % blend
- cfg_x, cfg_y, cfg_w, cfg_h  in  W_COORD  box origin and size in active pixels/lines
- cfg_thick  in  W_THK  border thickness; 0 = filled
- cfg_color  in  W_PIX  box colour
- vsync_o, hsync_o, de_o  out  1  timing delayed 4 cycles
- data_o  out  W_PIX  mixed pixel
- cfg_commit  out  1  one-cycle pulse when pending config becomes active

## Operation
- Config: two register banks per box (pending, active). cfg_we writes all fields of pending[cfg_idx]. On vsync rising edge (vsync=1, previous vsync=0), all pending banks are copied to active and cfg_commit pulses one cycle later. A cfg_we in the same cycle as the rising edge lands in pending only; the commit uses the pre-write pending value, so that write takes effect next frame.
- Coordinates: x counts de=1 cycles within a line, starting at 0; it clears on de falling edge. y counts active lines; it increments on de falling edge and clears on vsync rising edge. Both saturate at 2^W_COORD-1.
- Outer hit: x >= bx, x < bx+bw, y >= by, y < by+bh, with sums in W_COORD+1 bits. No wrap, so boxes past the edge clip. bw=0 or bh=0 never hits.
- Inner region: x >= bx+t, x < bx+bw-t, y >= by+t, y < by+bh-t. It is empty when 2t >= bw or 2t >= bh, making the box effectively filled.
- Box hit = en & de & outer & !inner. When t=0 the inner region is disabled, so box hit = en & de & outer.
- Select: the lowest-index hitting box supplies colour and blend mode.
- Mix: no hit gives data unchanged. Replace gives colour. Blend gives (data_lane + colour_lane) >> 1 per 8-bit lane, using a 9-bit sum with truncation.
- Pipeline:
  - S1: register inputs, x, y.
  - S2: per-box hit flags.
  - S3: priority select.
  - S4: mix and output register.
- Timing and data travel the same 4 stages.

## Timing
- Latency: input at cycle t appears on outputs at cycle t+4 for every input. Throughput is 1 pixel/clk, no stalls.
- Reset (asynchronous, rstn=0):
  - Outputs: vsync_o, hsync_o, de_o, data_o, cfg_commit all 0.
  - Registers: all pipeline registers 0; x and y 0; previous-vsync flag 0.
  - Config: all pending and active banks 0, so all boxes are disabled.
- Reset mid-frame: outputs go 0 immediately. After release, boxes stay disabled until a write followed by a vsync rising edge. Coordinates are valid from the next vsync.
- Active config never changes inside a frame. The commit and the y clear happen on the same edge, so the first active line uses the new config.
- hsync is passed through only; it does not affect the counters.

## Test plan
- Reset values:
  - Stimulus: rstn=0 with random inputs.
  - Response: all outputs 0.
  - Stimulus: release rstn, 64x16 frames, no cfg.
  - Response: data_o == data delayed 4, timing delayed 4, for 2 frames.
- Single filled box:
  - Config: box0 x=8, y=4, w=4, h=2, t=0, color=0x0000FF, replace; commit at vsync.
  - Response: exactly pixels x 8..11, y 4..5 equal 0x0000FF, and cfg_commit pulses once per vsync.
- Outline:
  - Config: box1 x=0, y=0, w=10, h=6, t=2.
  - Response: pixels (1,1) and (9,5) are hit, (2,2) through (7,3) are pass-through.
  - Config: t=5.
  - Response: the whole 10x6 box is filled.
- Priority and blend:
  - Config: box0 and box2 overlap at (20,8); box0 blend color=0xFF0000 over data 0x0000FE.
  - Response: data_o = 0x7F007F there, and box2 colour is not visible.
- Double buffering:
  - Stimulus: change box0 x mid-frame, and a cfg_we coincident with the vsync rise.
  - Response: the current frame is unchanged; the mid-frame write shows next frame; the coincident write shows one frame after that.
- Edge cases:
  - Stimulus: x=62, w=10 on a 64-wide line.
  - Response: columns 62..63 only, no wrap to column 0.
  - Stimulus: w=0.
  - Response: no hit.
  - Stimulus: cfg_idx=N_BOX.
  - Response: no config change.
  - Stimulus: rstn asserted mid-line.
  - Response: outputs 0 within the same cycle, and all boxes disabled after release.

Source files
------------

// File: rtl/video_box_overlay.sv
// Multi-box OSD overlay: N_BOX double-buffered rectangles (outline or filled,
// replace or 50% blend) mixed onto the video path through a fixed 4-stage pipe.
module video_box_overlay #(
  parameter int N_BOX   = 4,
  parameter int W_PIX   = 24,
  parameter int W_COORD = 12,
  parameter int W_THK   = 4,
  localparam int W_IDX  = (N_BOX > 1) ? $clog2(N_BOX) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               vsync,
  input  logic               hsync,
  input  logic               de,
  input  logic [W_PIX-1:0]   data,
  input  logic               cfg_we,
  input  logic [W_IDX-1:0]   cfg_idx,
  input  logic               cfg_en,
  input  logic               cfg_blend,
  input  logic [W_COORD-1:0] cfg_x,
  input  logic [W_COORD-1:0] cfg_y,
  input  logic [W_COORD-1:0] cfg_w,
  input  logic [W_COORD-1:0] cfg_h,
  input  logic [W_THK-1:0]   cfg_thick,
  input  logic [W_PIX-1:0]   cfg_color,
  output logic               vsync_o,
  output logic               hsync_o,
  output logic               de_o,
  output logic [W_PIX-1:0]   data_o,
  output logic               cfg_commit
);

  localparam int CW     = W_COORD + 1;
  localparam int N_LANE = W_PIX / 8;
  localparam logic [W_COORD-1:0] COORD_MAX = {W_COORD{1'b1}};

  // Sums are one bit wider than coordinates so boxes past the edge clip instead of wrapping.
  function automatic logic box_hit(
    input logic [W_COORD-1:0] px, input logic [W_COORD-1:0] py,
    input logic [W_COORD-1:0] bx, input logic [W_COORD-1:0] by,
    input logic [W_COORD-1:0] bw, input logic [W_COORD-1:0] bh,
    input logic [W_THK-1:0]   t
  );
    logic [CW-1:0] xe, ye, x0, y0, x1, y1, te, t2;
    logic          outer, inner_ok, inner;
    xe       = {1'b0, px};
    ye       = {1'b0, py};
    x0       = {1'b0, bx};
    y0       = {1'b0, by};
    x1       = x0 + {1'b0, bw};
    y1       = y0 + {1'b0, bh};
    te       = CW'(t);
    t2       = {te[CW-2:0], 1'b0};
    outer    = (xe >= x0) && (xe < x1) && (ye >= y0) && (ye < y1);
    inner_ok = (t != {W_THK{1'b0}}) && (t2 < {1'b0, bw}) && (t2 < {1'b0, bh});
    inner    = (xe >= x0 + te) && (xe < x1 - te) && (ye >= y0 + te) && (ye < y1 - te);
    return outer && !(inner_ok && inner);
  endfunction

  function automatic logic [7:0] lane_avg(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8:1];
  endfunction

  logic               vsync_prev_r, de_prev_r;
  logic [W_COORD-1:0] x_cnt_r, y_cnt_r;
  logic               vsync_rise_s, de_fall_s;

  logic               pend_en_r    [N_BOX];
  logic               pend_blend_r [N_BOX];
  logic [W_COORD-1:0] pend_x_r     [N_BOX];
  logic [W_COORD-1:0] pend_y_r     [N_BOX];
  logic [W_COORD-1:0] pend_w_r     [N_BOX];
  logic [W_COORD-1:0] pend_h_r     [N_BOX];
  logic [W_THK-1:0]   pend_thick_r [N_BOX];
  logic [W_PIX-1:0]   pend_color_r [N_BOX];
  logic               act_en_r     [N_BOX];
  logic               act_blend_r  [N_BOX];
  logic [W_COORD-1:0] act_x_r      [N_BOX];
  logic [W_COORD-1:0] act_y_r      [N_BOX];
  logic [W_COORD-1:0] act_w_r      [N_BOX];
  logic [W_COORD-1:0] act_h_r      [N_BOX];
  logic [W_THK-1:0]   act_thick_r  [N_BOX];
  logic [W_PIX-1:0]   act_color_r  [N_BOX];

  logic               s1_vs_r, s1_hs_r, s1_de_r;
  logic [W_PIX-1:0]   s1_data_r;
  logic [W_COORD-1:0] s1_x_r, s1_y_r;
  logic               s2_vs_r, s2_hs_r, s2_de_r;
  logic [W_PIX-1:0]   s2_data_r;
  logic [N_BOX-1:0]   s2_hit_r;
  logic               s3_vs_r, s3_hs_r, s3_de_r, s3_hit_r, s3_blend_r;
  logic [W_PIX-1:0]   s3_data_r, s3_color_r;

  logic [N_BOX-1:0]   hit_s;
  logic               sel_hit_s, sel_blend_s;
  logic [W_PIX-1:0]   sel_color_s, blend_s, mix_s;

  assign vsync_rise_s = vsync & ~vsync_prev_r;
  assign de_fall_s    = ~de & de_prev_r;

  // Active-area x/y counters; y clears on the same edge that commits config.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vsync_prev_r <= 1'b0;
      de_prev_r    <= 1'b0;
      x_cnt_r      <= {W_COORD{1'b0}};
      y_cnt_r      <= {W_COORD{1'b0}};
    end else begin
      vsync_prev_r <= vsync;
      de_prev_r    <= de;
      if (de_fall_s)
        x_cnt_r <= {W_COORD{1'b0}};
      else if (de && (x_cnt_r != COORD_MAX))
        x_cnt_r <= x_cnt_r + {{(W_COORD-1){1'b0}}, 1'b1};
      if (vsync_rise_s)
        y_cnt_r <= {W_COORD{1'b0}};
      else if (de_fall_s && (y_cnt_r != COORD_MAX))
        y_cnt_r <= y_cnt_r + {{(W_COORD-1){1'b0}}, 1'b1};
    end
  end

  // Pending banks take writes; active banks copy the pre-write pending value on vsync rise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_BOX; i++) begin
        pend_en_r[i]    <= 1'b0;
        pend_blend_r[i] <= 1'b0;
        pend_x_r[i]     <= {W_COORD{1'b0}};
        pend_y_r[i]     <= {W_COORD{1'b0}};
        pend_w_r[i]     <= {W_COORD{1'b0}};
        pend_h_r[i]     <= {W_COORD{1'b0}};
        pend_thick_r[i] <= {W_THK{1'b0}};
        pend_color_r[i] <= {W_PIX{1'b0}};
        act_en_r[i]     <= 1'b0;
        act_blend_r[i]  <= 1'b0;
        act_x_r[i]      <= {W_COORD{1'b0}};
        act_y_r[i]      <= {W_COORD{1'b0}};
        act_w_r[i]      <= {W_COORD{1'b0}};
        act_h_r[i]      <= {W_COORD{1'b0}};
        act_thick_r[i]  <= {W_THK{1'b0}};
        act_color_r[i]  <= {W_PIX{1'b0}};
      end
      cfg_commit <= 1'b0;
    end else begin
      for (int i = 0; i < N_BOX; i++) begin
        if (cfg_we && (cfg_idx == W_IDX'(i))) begin
          pend_en_r[i]    <= cfg_en;
          pend_blend_r[i] <= cfg_blend;
          pend_x_r[i]     <= cfg_x;
          pend_y_r[i]     <= cfg_y;
          pend_w_r[i]     <= cfg_w;
          pend_h_r[i]     <= cfg_h;
          pend_thick_r[i] <= cfg_thick;
          pend_color_r[i] <= cfg_color;
        end
        if (vsync_rise_s) begin
          act_en_r[i]    <= pend_en_r[i];
          act_blend_r[i] <= pend_blend_r[i];
          act_x_r[i]     <= pend_x_r[i];
          act_y_r[i]     <= pend_y_r[i];
          act_w_r[i]     <= pend_w_r[i];
          act_h_r[i]     <= pend_h_r[i];
          act_thick_r[i] <= pend_thick_r[i];
          act_color_r[i] <= pend_color_r[i];
        end
      end
      cfg_commit <= vsync_rise_s;
    end
  end

  // Per-box hit flags for the pixel held in stage 1.
  always_comb begin
    hit_s = {N_BOX{1'b0}};
    for (int i = 0; i < N_BOX; i++)
      hit_s[i] = act_en_r[i] & s1_de_r &
                 box_hit(s1_x_r, s1_y_r, act_x_r[i], act_y_r[i],
                         act_w_r[i], act_h_r[i], act_thick_r[i]);
  end

  // Priority select: scanning from the top index down lets box 0 win.
  always_comb begin
    sel_hit_s   = 1'b0;
    sel_blend_s = 1'b0;
    sel_color_s = {W_PIX{1'b0}};
    for (int i = N_BOX - 1; i >= 0; i--) begin
      sel_color_s = s2_hit_r[i] ? act_color_r[i] : sel_color_s;
      sel_blend_s = s2_hit_r[i] ? act_blend_r[i] : sel_blend_s;
      sel_hit_s   = s2_hit_r[i] | sel_hit_s;
    end
  end

  // Mixer: pass-through, replace, or per-lane truncated average.
  always_comb begin
    blend_s = {W_PIX{1'b0}};
    mix_s   = s3_data_r;
    for (int l = 0; l < N_LANE; l++)
      blend_s[l*8 +: 8] = lane_avg(s3_data_r[l*8 +: 8], s3_color_r[l*8 +: 8]);
    if (!s3_hit_r)
      mix_s = s3_data_r;
    else if (s3_blend_r)
      mix_s = blend_s;
    else
      mix_s = s3_color_r;
  end

  // Four-stage pipe; timing rides alongside data so all outputs line up.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vs_r    <= 1'b0;
      s1_hs_r    <= 1'b0;
      s1_de_r    <= 1'b0;
      s1_data_r  <= {W_PIX{1'b0}};
      s1_x_r     <= {W_COORD{1'b0}};
      s1_y_r     <= {W_COORD{1'b0}};
      s2_vs_r    <= 1'b0;
      s2_hs_r    <= 1'b0;
      s2_de_r    <= 1'b0;
      s2_data_r  <= {W_PIX{1'b0}};
      s2_hit_r   <= {N_BOX{1'b0}};
      s3_vs_r    <= 1'b0;
      s3_hs_r    <= 1'b0;
      s3_de_r    <= 1'b0;
      s3_data_r  <= {W_PIX{1'b0}};
      s3_hit_r   <= 1'b0;
      s3_blend_r <= 1'b0;
      s3_color_r <= {W_PIX{1'b0}};
      vsync_o    <= 1'b0;
      hsync_o    <= 1'b0;
      de_o       <= 1'b0;
      data_o     <= {W_PIX{1'b0}};
    end else begin
      s1_vs_r    <= vsync;
      s1_hs_r    <= hsync;
      s1_de_r    <= de;
      s1_data_r  <= data;
      s1_x_r     <= x_cnt_r;
      s1_y_r     <= y_cnt_r;
      s2_vs_r    <= s1_vs_r;
      s2_hs_r    <= s1_hs_r;
      s2_de_r    <= s1_de_r;
      s2_data_r  <= s1_data_r;
      s2_hit_r   <= hit_s;
      s3_vs_r    <= s2_vs_r;
      s3_hs_r    <= s2_hs_r;
      s3_de_r    <= s2_de_r;
      s3_data_r  <= s2_data_r;
      s3_hit_r   <= sel_hit_s;
      s3_blend_r <= sel_blend_s;
      s3_color_r <= sel_color_s;
      vsync_o    <= s3_vs_r;
      hsync_o    <= s3_hs_r;
      de_o       <= s3_de_r;
      data_o     <= mix_s;
    end
  end

endmodule

// File: tb/tb_video_box_overlay.sv
// Directed bench for video_box_overlay: 64x16 frames, per-pixel capture of
// the 4-cycle-delayed output compared against hand-derived expected images.
module tb_video_box_overlay;

  typedef struct packed {
    logic [1:0]  idx;
    logic        en;
    logic        blend;
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] w;
    logic [11:0] h;
    logic [3:0]  t;
    logic [23:0] color;
  } cfg_t;

  logic        clk, rstn;
  logic        vsync, hsync, de, cfg_we, cfg_en, cfg_blend;
  logic [23:0] data, cfg_color;
  logic [1:0]  cfg_idx;
  logic [11:0] cfg_x, cfg_y, cfg_w, cfg_h;
  logic [3:0]  cfg_thick;
  logic        vsync_o, hsync_o, de_o, cfg_commit;
  logic [23:0] data_o;

  int errors = 0;
  int checks = 0;
  int cyc = 8;
  int tim_err, commit_cnt, nbad, fx, fy;
  logic        mon_en;
  logic [23:0] fa, fe;
  logic        h_vs [8];
  logic        h_hs [8];
  logic        h_de [8];
  logic [23:0] h_data [8];
  int          h_x [8];
  int          h_y [8];
  logic [23:0] cap  [16][64];
  logic [23:0] expf [16][64];
  cfg_t        none;

  video_box_overlay #(.N_BOX(3), .W_PIX(24), .W_COORD(12), .W_THK(4)) dut (
    .clk(clk), .rstn(rstn), .vsync(vsync), .hsync(hsync), .de(de), .data(data),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_blend(cfg_blend),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .cfg_thick(cfg_thick), .cfg_color(cfg_color),
    .vsync_o(vsync_o), .hsync_o(hsync_o), .de_o(de_o), .data_o(data_o),
    .cfg_commit(cfg_commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] pix(input int px, input int py);
    if (px == 20 && py == 8) return 24'h0000FE;
    return {8'(px * 3 + 1), 8'(py * 29 + 7), 8'(px + py * 5)};
  endfunction

  function automatic cfg_t mk(input int idx, input int en, input int bl, input int x,
                              input int y, input int w, input int h, input int t,
                              input logic [23:0] col);
    cfg_t c;
    c.idx = 2'(idx); c.en = 1'(en); c.blend = 1'(bl);
    c.x = 12'(x); c.y = 12'(y); c.w = 12'(w); c.h = 12'(h);
    c.t = 4'(t); c.color = col;
    return c;
  endfunction

  task automatic apply_cfg(input cfg_t c);
    cfg_idx = c.idx; cfg_en = c.en; cfg_blend = c.blend;
    cfg_x = c.x; cfg_y = c.y; cfg_w = c.w; cfg_h = c.h;
    cfg_thick = c.t; cfg_color = c.color;
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 8; i++) begin
      h_vs[i] = 1'b0; h_hs[i] = 1'b0; h_de[i] = 1'b0;
      h_data[i] = 24'h0; h_x[i] = 0; h_y[i] = 0;
    end
  endtask

  // One pixel clock: drive inputs, sample outputs at negedge against the input of 4 cycles ago.
  task automatic tick(input logic v, input logic h, input logic d, input logic [23:0] dat,
                      input int px, input int py);
    int k;
    vsync = v; hsync = h; de = d; data = dat;
    k = cyc & 7;
    h_vs[k] = v; h_hs[k] = h; h_de[k] = d; h_data[k] = dat; h_x[k] = px; h_y[k] = py;
    @(negedge clk);
    if (mon_en) begin
      k = (cyc - 4) & 7;
      if (vsync_o !== h_vs[k] || hsync_o !== h_hs[k] || de_o !== h_de[k]) tim_err++;
      if (h_de[k]) cap[h_y[k]][h_x[k]] = data_o;
      else if (data_o !== h_data[k]) tim_err++;
      if (cfg_commit === 1'b1) commit_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cfg_write(input cfg_t c);
    apply_cfg(c);
    cfg_we = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
    cfg_we = 1'b0;
  endtask

  task automatic run_frame(input logic vs_we, input cfg_t vs_c, input logic mid_we, input cfg_t mid_c);
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 64; xx++) cap[yy][xx] = 24'hxxxxxx;
    tim_err = 0;
    commit_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 0 && vs_we) begin apply_cfg(vs_c); cfg_we = 1'b1; end
      tick(1'b1, 1'b0, 1'b0, 24'($urandom), 0, 0);
      cfg_we = 1'b0;
    end
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 24'($urandom), 0, 0);
    for (int yy = 0; yy < 16; yy++) begin
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 24'($urandom), 0, 0);
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 24'($urandom), 0, 0);
      for (int xx = 0; xx < 64; xx++) begin
        if (mid_we && yy == 8 && xx == 0) begin apply_cfg(mid_c); cfg_we = 1'b1; end
        tick(1'b0, 1'b0, 1'b1, pix(xx, yy), xx, yy);
        cfg_we = 1'b0;
      end
    end
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0, 24'($urandom), 0, 0);
  endtask

  task automatic exp_pass();
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 64; xx++) expf[yy][xx] = pix(xx, yy);
  endtask

  task automatic exp_rect(input int x0, input int x1, input int y0, input int y1, input logic [23:0] col);
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = x0; xx <= x1; xx++) expf[yy][xx] = col;
  endtask

  task automatic frame_diff(output int n);
    n = 0;
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 64; xx++)
        if (cap[yy][xx] !== expf[yy][xx]) begin
          if (n == 0) begin fx = xx; fy = yy; fa = cap[yy][xx]; fe = expf[yy][xx]; end
          n++;
        end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vsync = 1'($urandom); hsync = 1'($urandom); de = 1'($urandom); data = 24'($urandom);
      cfg_we = 1'($urandom); apply_cfg(cfg_t'({$urandom, $urandom, $urandom}));
      @(negedge clk);
      checks++;
      if ({vsync_o, hsync_o, de_o, data_o, cfg_commit} !== 28'h0) begin
        errors++;
        $display("FAIL reset_outputs: got %h want 0", {vsync_o, hsync_o, de_o, data_o, cfg_commit});
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    vsync = 1'b0; hsync = 1'b0; de = 1'b0; data = 24'h0; cfg_we = 1'b0;
    clear_hist();
    rstn = 1'b1;
    mon_en = 1'b1;
    for (int f = 0; f < 2; f++) begin
      run_frame(1'b0, none, 1'b0, none);
      exp_pass(); frame_diff(nbad);
      checks++; if (nbad !== 0) begin errors++; $display("FAIL reset_passthru_pix f%0d: %0d wrong, first (%0d,%0d) got %h want %h", f, nbad, fx, fy, fa, fe); end
      checks++; if (tim_err !== 0) begin errors++; $display("FAIL reset_passthru_timing f%0d: %0d bad cycles, want 0", f, tim_err); end
      checks++; if (commit_cnt !== 1) begin errors++; $display("FAIL reset_commit f%0d: got %0d pulses want 1", f, commit_cnt); end
    end
  endtask

  task automatic test_filled();
    cfg_write(mk(0, 1, 0, 8, 4, 4, 2, 0, 24'h0000FF));
    run_frame(1'b0, none, 1'b0, none);
    exp_pass(); exp_rect(8, 11, 4, 5, 24'h0000FF); frame_diff(nbad);
    checks++; if (nbad !== 0) begin errors++; $display("FAIL filled_pix: %0d wrong, first (%0d,%0d) got %h want %h", nbad, fx, fy, fa, fe); end
    checks++; if (tim_err !== 0) begin errors++; $display("FAIL filled_timing: %0d bad cycles, want 0", tim_err); end
    checks++; if (commit_cnt !== 1) begin errors++; $display("FAIL filled_commit: got %0d pulses want 1", commit_cnt); end
    checks++; if (cap[4][12] !== pix(12, 4)) begin errors++; $display("FAIL filled_right_edge: got %h want %h", cap[4][12], pix(12, 4)); end
  endtask

  task automatic test_outline();
    cfg_write(mk(0, 0, 0, 8, 4, 4, 2, 0, 24'h0000FF));
    cfg_write(mk(1, 1, 0, 0, 0, 10, 6, 2, 24'h00FF00));
    run_frame(1'b0, none, 1'b0, none);
    exp_pass(); exp_rect(0, 9, 0, 5, 24'h00FF00);
    for (int yy = 2; yy <= 3; yy++)
      for (int xx = 2; xx <= 7; xx++) expf[yy][xx] = pix(xx, yy);
    frame_diff(nbad);
    checks++; if (nbad !== 0) begin errors++; $display("FAIL outline_pix: %0d wrong, first (%0d,%0d) got %h want %h", nbad, fx, fy, fa, fe); end
    checks++; if (tim_err !== 0) begin errors++; $display("FAIL outline_timing: %0d bad cycles, want 0", tim_err); end
    checks++; if (cap[1][1] !== 24'h00FF00) begin errors++; $display("FAIL outline_1_1: got %h want 00ff00", cap[1][1]); end
    checks++; if (cap[5][9] !== 24'h00FF00) begin errors++; $display("FAIL outline_9_5: got %h want 00ff00", cap[5][9]); end
    checks++; if (cap[2][2] !== pix(2, 2)) begin errors++; $display("FAIL outline_2_2: got %h want %h", cap[2][2], pix(2, 2)); end
    checks++; if (cap[3][7] !== pix(7, 3)) begin errors++; $display("FAIL outline_7_3: got %h want %h", cap[3][7], pix(7, 3)); end
    cfg_write(mk(1, 1, 0, 0, 0, 10, 6, 5, 24'h00FF00));
    run_frame(1'b0, none, 1'b0, none);
    exp_pass(); exp_rect(0, 9, 0, 5, 24'h00FF00); frame_diff(nbad);
    checks++; if (nbad !== 0) begin errors++; $display("FAIL thick5_pix: %0d wrong, first (%0d,%0d) got %h want %h", nbad, fx, fy, fa, fe); end
    checks++; if (commit_cnt !== 1) begin errors++; $display("FAIL thick5_commit: got %0d pulses want 1", commit_cnt); end
  endtask

  task automatic test_priority_blend();
    cfg_write(mk(1, 0, 0, 0, 0, 10, 6, 5, 24'h00FF00));
    cfg_write(mk(0, 1, 1, 20, 8, 1, 1, 0, 24'hFF0000));
    cfg_write(mk(2, 1, 0, 18, 7, 5, 3, 0, 24'h00FF00));
    run_frame(1'b0, none, 1'b0, none);
    exp_pass(); exp_rect(18, 22, 7, 9, 24'h00FF00); expf[8][20] = 24'h7F007F; frame_diff(nbad);
    checks++; if (nbad !== 0) begin errors++; $display("FAIL prio_pix: %0d wrong, first (%0d,%0d) got %h want %h", nbad, fx, fy, fa, fe); end
    checks++; if (tim_err !== 0) begin errors++; $display("FAIL prio_timing: %0d bad cycles, want 0", tim_err); end
    checks++; if (cap[8][20] !== 24'h7F007F) begin errors++; $display("FAIL blend_20_8: got %h want 7f007f", cap[8][20]); end
  endtask

  task automatic test_double_buffer();
    int xs [3];
    xs[0] = 4; xs[1] = 30; xs[2] = 50;
    cfg_write(mk(2, 0, 0, 18, 7, 5, 3, 0, 24'h00FF00));
    cfg_write(mk(0, 1, 0, 4, 0, 2, 16, 0, 24'h123456));
    for (int f = 0; f < 3; f++) begin
      run_frame(f == 1, mk(0, 1, 0, 50, 0, 2, 16, 0, 24'h123456),
                f == 0, mk(0, 1, 0, 30, 0, 2, 16, 0, 24'h123456));
      exp_pass(); exp_rect(xs[f], xs[f] + 1, 0, 15, 24'h123456); frame_diff(nbad);
      checks++; if (nbad !== 0) begin errors++; $display("FAIL dbuf_pix f%0d: %0d wrong, first (%0d,%0d) got %h want %h", f, nbad, fx, fy, fa, fe); end
      checks++; if (commit_cnt !== 1) begin errors++; $display("FAIL dbuf_commit f%0d: got %0d pulses want 1", f, commit_cnt); end
    end
  endtask

  task automatic test_edges();
    cfg_write(mk(0, 1, 0, 62, 0, 10, 16, 0, 24'hAA55AA));
    cfg_write(mk(1, 1, 0, 0, 0, 0, 16, 0, 24'h0000FF));
    cfg_write(mk(3, 1, 0, 0, 0, 64, 16, 0, 24'hFFFFFF));
    run_frame(1'b0, none, 1'b0, none);
    exp_pass(); exp_rect(62, 63, 0, 15, 24'hAA55AA); frame_diff(nbad);
    checks++; if (nbad !== 0) begin errors++; $display("FAIL edge_pix: %0d wrong, first (%0d,%0d) got %h want %h", nbad, fx, fy, fa, fe); end
    checks++; if (tim_err !== 0) begin errors++; $display("FAIL edge_timing: %0d bad cycles, want 0", tim_err); end
    checks++; if (cap[5][0] !== pix(0, 5)) begin errors++; $display("FAIL edge_nowrap: got %h want %h", cap[5][0], pix(0, 5)); end
    checks++; if (cap[5][63] !== 24'hAA55AA) begin errors++; $display("FAIL edge_col63: got %h want aa55aa", cap[5][63]); end
  endtask

  task automatic test_reset_midline();
    cfg_write(mk(0, 1, 0, 0, 0, 64, 16, 0, 24'hC0FFEE));
    cap[0][10] = 24'hxxxxxx;
    tick(1'b1, 1'b0, 1'b0, 24'h0, 0, 0);
    tick(1'b1, 1'b0, 1'b0, 24'h0, 0, 0);
    tick(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
    tick(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
    for (int xx = 0; xx < 30; xx++) tick(1'b0, 1'b0, 1'b1, pix(xx, 0), xx, 0);
    checks++; if (cap[0][10] !== 24'hC0FFEE) begin errors++; $display("FAIL midrst_prehit: got %h want c0ffee", cap[0][10]); end
    de = 1'b1; data = pix(30, 0);
    #2;
    rstn = 1'b0;
    mon_en = 1'b0;
    #1;
    checks++;
    if ({vsync_o, hsync_o, de_o, data_o, cfg_commit} !== 28'h0) begin
      errors++;
      $display("FAIL midrst_outputs: got %h want 0", {vsync_o, hsync_o, de_o, data_o, cfg_commit});
    end
    @(posedge clk);
    #1;
    cyc++;
    de = 1'b0; data = 24'h0;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
    clear_hist();
    rstn = 1'b1;
    mon_en = 1'b1;
    run_frame(1'b0, none, 1'b0, none);
    exp_pass(); frame_diff(nbad);
    checks++; if (nbad !== 0) begin errors++; $display("FAIL midrst_disabled_pix: %0d wrong, first (%0d,%0d) got %h want %h", nbad, fx, fy, fa, fe); end
    checks++; if (tim_err !== 0) begin errors++; $display("FAIL midrst_timing: %0d bad cycles, want 0", tim_err); end
    checks++; if (commit_cnt !== 1) begin errors++; $display("FAIL midrst_commit: got %0d pulses want 1", commit_cnt); end
  endtask

  initial begin
    rstn = 1'b0; mon_en = 1'b0; none = '0;
    vsync = 1'b0; hsync = 1'b0; de = 1'b0; data = 24'h0; cfg_we = 1'b0;
    apply_cfg(none);
    clear_hist();
    @(posedge clk);
    #1;
    test_reset();
    test_filled();
    test_outline();
    test_priority_blend();
    test_double_buffer();
    test_edges();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
